// File: rtl/io_pad_bank.sv
// GPIO pad bank: registered push-pull/open-drain drive, synchronised glitch-filtered input, sticky edge interrupts.
// Latency: 1 clk out_* -> pad; SYNC_STAGES+F+1 clk pad_p2c -> in_value/irq_pending.
// Backpressure: none; every input is sampled each cycle.
module io_pad_bank #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_BITS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       out_value,
   input  logic [WIDTH-1:0]       out_enable,
   input  logic [WIDTH-1:0]       open_drain,
   input  logic [FILTER_BITS-1:0] filter_cycles,
   input  logic [WIDTH-1:0]       irq_rise_en,
   input  logic [WIDTH-1:0]       irq_fall_en,
   input  logic [WIDTH-1:0]       irq_clear,
   output logic [WIDTH-1:0]       in_value,
   output logic [WIDTH-1:0]       irq_pending,
   output logic                   irq,
   output logic [WIDTH-1:0]       pad_c2p,
   output logic [WIDTH-1:0]       pad_c2p_en,
   input  logic [WIDTH-1:0]       pad_p2c
);

   logic [WIDTH-1:0]       c2p_q, c2p_d;
   logic [WIDTH-1:0]       c2p_en_q, c2p_en_d;
   logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]       sync;
   logic [WIDTH-1:0]       stable_q, stable_d;
   logic [FILTER_BITS-1:0] cnt_q [WIDTH];
   logic [FILTER_BITS-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0]       pend_q, pend_d;
   logic [WIDTH-1:0]       rise, fall;

   // Open-drain never drives high: it pulls low or releases the pad.
   always_comb begin
      c2p_d    = out_value & ~open_drain;
      c2p_en_d = out_enable & (~open_drain | ~out_value);
   end

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= filter_cycles) begin
            stable_d[i] = sync[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + FILTER_BITS'(1);
         end
      end
   end

   // A new event wins over a same-cycle clear so no edge is lost.
   always_comb begin
      rise   = stable_d & ~stable_q;
      fall   = ~stable_d & stable_q;
      pend_d = (rise & irq_rise_en) | (fall & irq_fall_en) | (pend_q & ~irq_clear);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         c2p_q    <= '0;
         c2p_en_q <= '0;
         stable_q <= '0;
         pend_q   <= '0;
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         c2p_q    <= c2p_d;
         c2p_en_q <= c2p_en_d;
         stable_q <= stable_d;
         pend_q   <= pend_d;
         sync_q[0] <= pad_p2c;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign pad_c2p     = c2p_q;
   assign pad_c2p_en  = c2p_en_q;
   assign in_value    = stable_q;
   assign irq_pending = pend_q;
   assign irq         = |pend_q;

endmodule
